// File: rtl/immediate_encoder.sv
// Splits a signed byte into 2-bit immediates: one chunk when the value fits in
// two bits (-2..1), otherwise four chunks sent MSB-first, with valid/ready handshakes.
module immediate_encoder #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         value,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [1:0]         immediate,
   output logic               imm_valid,
   output logic               imm_last,
   output logic               imm_short,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] long_count
);

   typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

   state_t               state_q, state_d;
   logic [7:0]           hold_q, hold_d;
   logic [1:0]           idx_q, idx_d;
   logic [1:0]           imm_q, imm_d;
   logic                 last_q, last_d;
   logic                 short_q, short_d;
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic                 is_short;

   function automatic logic [1:0] chunk_sel(input logic [7:0] w, input logic [1:0] idx);
      logic [1:0] c;
      case (idx)
         2'd0:    c = w[7:6];
         2'd1:    c = w[5:4];
         2'd2:    c = w[3:2];
         default: c = w[1:0];
      endcase
      return c;
   endfunction

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (&c) ? c : c + COUNT_W'(1);
   endfunction

   // A value fits one chunk when bits [7:1] are pure sign extension of bit 1
   assign is_short = (&value[7:1]) | ~(|value[7:1]);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      imm_d   = imm_q;
      last_d  = last_q;
      short_d = short_q;
      ready_d = ready_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               ready_d = 1'b0;
               valid_d = 1'b1;
               if (is_short) begin
                  state_d = SHORT;
                  imm_d   = value[1:0];
                  last_d  = 1'b1;
                  short_d = 1'b1;
               end else begin
                  state_d = LONG;
                  hold_d  = value;
                  idx_d   = 2'd0;
                  imm_d   = value[7:6];
                  last_d  = 1'b0;
                  short_d = 1'b0;
                  cnt_d   = sat_inc(cnt_q);
               end
            end
         end
         SHORT: begin
            if (out_ready) begin
               state_d = IDLE;
               imm_d   = 2'b00;
               last_d  = 1'b0;
               short_d = 1'b0;
               valid_d = 1'b0;
               ready_d = 1'b1;
            end
         end
         LONG: begin
            if (out_ready) begin
               if (idx_q == 2'd3) begin
                  state_d = IDLE;
                  idx_d   = 2'd0;
                  imm_d   = 2'b00;
                  last_d  = 1'b0;
                  valid_d = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  idx_d  = idx_q + 2'd1;
                  imm_d  = chunk_sel(hold_q, idx_q + 2'd1);
                  last_d = (idx_q == 2'd2);
               end
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= 8'h00;
         idx_q   <= 2'd0;
         imm_q   <= 2'b00;
         last_q  <= 1'b0;
         short_q <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         imm_q   <= imm_d;
         last_q  <= last_d;
         short_q <= short_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready   = ready_q;
   assign imm_valid  = valid_q;
   assign immediate  = imm_q;
   assign imm_last   = last_q;
   assign imm_short  = short_q;
   assign long_count = cnt_q;

endmodule
